// File: rtl/types.sv
// Shared datapath types: bus width and the ALU operation encoding used on the a/b/sel -> s interface.
package types;

   typedef logic [31:0] bus_type;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU
   } alu_oper_type;

endpackage

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes instructions, feeds the ALU from an issue register and
// registers the ALU result with write-back and branch-resolution control.
module alu_issue_stage
   import types::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [5:0]          in_opcode,
   input  logic [5:0]          in_funct,
   input  logic [DATA_W-1:0]   in_rs_val,
   input  logic [DATA_W-1:0]   in_rt_val,
   input  logic [15:0]         in_imm,
   input  logic [4:0]          in_rt,
   input  logic [4:0]          in_rd,
   input  logic [DATA_W-1:0]   in_pc,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output alu_oper_type        alu_sel,
   input  logic [DATA_W-1:0]   alu_s,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_result,
   output logic [4:0]          out_dest,
   output logic                out_we,
   output logic                out_br_taken,
   output logic [DATA_W-1:0]   out_br_target,
   output logic                out_illegal
);

   typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_kind_e;

   // Decode
   alu_oper_type        w_dec_sel;
   logic [DATA_W-1:0]   w_dec_b;
   logic [4:0]          w_dec_dest;
   br_kind_e            w_dec_br;
   logic                w_dec_illegal;
   logic                w_dec_we;
   logic [DATA_W-1:0]   w_sext;
   logic [DATA_W-1:0]   w_zext;
   logic [DATA_W-1:0]   w_target;

   assign w_sext   = {{(DATA_W-16){in_imm[15]}}, in_imm};
   assign w_zext   = {{(DATA_W-16){1'b0}}, in_imm};
   assign w_target = in_pc + DATA_W'(4) + (w_sext << 2);

   always_comb begin
      w_dec_sel     = ALU_ADD;
      w_dec_b       = in_rt_val;
      w_dec_dest    = in_rd;
      w_dec_br      = BrNone;
      w_dec_illegal = 1'b0;
      unique case (in_opcode)
         6'h00: begin
            unique case (in_funct)
               6'h20, 6'h21: w_dec_sel = ALU_ADD;
               6'h22, 6'h23: w_dec_sel = ALU_SUB;
               6'h24:        w_dec_sel = ALU_AND;
               6'h25:        w_dec_sel = ALU_OR;
               6'h27:        w_dec_sel = ALU_NOR;
               6'h2A:        w_dec_sel = ALU_SLT;
               6'h2B:        w_dec_sel = ALU_SLTU;
               default:      w_dec_illegal = 1'b1;
            endcase
         end
         6'h08, 6'h09: begin
            w_dec_sel  = ALU_ADD;
            w_dec_b    = w_sext;
            w_dec_dest = in_rt;
         end
         6'h0A: begin
            w_dec_sel  = ALU_SLT;
            w_dec_b    = w_sext;
            w_dec_dest = in_rt;
         end
         6'h0B: begin
            w_dec_sel  = ALU_SLTU;
            w_dec_b    = w_sext;
            w_dec_dest = in_rt;
         end
         6'h0C: begin
            w_dec_sel  = ALU_AND;
            w_dec_b    = w_zext;
            w_dec_dest = in_rt;
         end
         6'h0D: begin
            w_dec_sel  = ALU_OR;
            w_dec_b    = w_zext;
            w_dec_dest = in_rt;
         end
         6'h04: begin
            w_dec_sel  = ALU_SUB;
            w_dec_br   = BrEq;
            w_dec_dest = 5'd0;
         end
         6'h05: begin
            w_dec_sel  = ALU_SUB;
            w_dec_br   = BrNe;
            w_dec_dest = 5'd0;
         end
         default: w_dec_illegal = 1'b1;
      endcase
   end

   assign w_dec_we = !w_dec_illegal && (w_dec_br == BrNone) && (w_dec_dest != 5'd0);

   // Stage 1: issue register
   logic                r_s1_valid;
   alu_oper_type        r_s1_sel;
   logic [DATA_W-1:0]   r_s1_a;
   logic [DATA_W-1:0]   r_s1_b;
   logic [4:0]          r_s1_dest;
   logic                r_s1_we;
   br_kind_e            r_s1_br;
   logic [DATA_W-1:0]   r_s1_target;
   logic                r_s1_illegal;

   // Stage 2: result register
   logic                r_s2_valid;
   logic [DATA_W-1:0]   r_s2_result;
   logic [4:0]          r_s2_dest;
   logic                r_s2_we;
   logic                r_s2_taken;
   logic [DATA_W-1:0]   r_s2_target;
   logic                r_s2_illegal;

   logic                w_s1_adv;
   logic                w_s1_load;
   logic                w_zero;
   logic                w_taken;

   assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !flush && (!r_s1_valid || w_s1_adv);
   assign w_s1_load = in_valid && in_ready;
   assign w_zero    = (alu_s == '0);
   assign w_taken   = ((r_s1_br == BrEq) && w_zero) || ((r_s1_br == BrNe) && !w_zero);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_sel     <= ALU_ADD;
         r_s1_a       <= '0;
         r_s1_b       <= '0;
         r_s1_dest    <= '0;
         r_s1_we      <= 1'b0;
         r_s1_br      <= BrNone;
         r_s1_target  <= '0;
         r_s1_illegal <= 1'b0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s1_load) begin
            r_s1_sel     <= w_dec_sel;
            r_s1_a       <= in_rs_val;
            r_s1_b       <= w_dec_b;
            r_s1_dest    <= w_dec_dest;
            r_s1_we      <= w_dec_we;
            r_s1_br      <= w_dec_br;
            r_s1_target  <= w_target;
            r_s1_illegal <= w_dec_illegal;
         end
      end
   end

   // Data is only captured on a real advance so held outputs never glitch under flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_result  <= '0;
         r_s2_dest    <= '0;
         r_s2_we      <= 1'b0;
         r_s2_taken   <= 1'b0;
         r_s2_target  <= '0;
         r_s2_illegal <= 1'b0;
      end else begin
         if (flush) begin
            r_s2_valid <= 1'b0;
         end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
         end else if (out_ready) begin
            r_s2_valid <= 1'b0;
         end
         if (w_s1_adv && !flush) begin
            r_s2_result  <= alu_s;
            r_s2_dest    <= r_s1_dest;
            r_s2_we      <= r_s1_we;
            r_s2_taken   <= w_taken;
            r_s2_target  <= r_s1_target;
            r_s2_illegal <= r_s1_illegal;
         end
      end
   end

   assign alu_a   = r_s1_valid ? r_s1_a : '0;
   assign alu_b   = r_s1_valid ? r_s1_b : '0;
   assign alu_sel = r_s1_valid ? r_s1_sel : ALU_ADD;

   assign out_valid     = r_s2_valid;
   assign out_result    = r_s2_result;
   assign out_dest      = r_s2_dest;
   assign out_we        = r_s2_we;
   assign out_br_taken  = r_s2_taken;
   assign out_br_target = r_s2_target;
   assign out_illegal   = r_s2_illegal;

endmodule
